// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice: fetch-state
// encoding, PC width, sequential increment and default reset vector.
package mips_pkg;

   localparam int              PC_W                 = 32;
   localparam logic [PC_W-1:0] PC_INC               = 32'd4;
   localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_HALT = 3'd4
   } fetch_state_t;

   // A redirect target must be word aligned; anything else is fatal.
   function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/mips_fetch_pc.sv
// Program counter for the fetch unit: reset to the reset vector, load on
// redirect, otherwise advance by one word when asked. Wraps modulo 2^32.
module mips_fetch_pc
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            LOAD,
   input  logic [PC_W-1:0] LOAD_PC,
   input  logic            INC,
   output logic [PC_W-1:0] PC
);

   logic [PC_W-1:0] pc_reg;

   // PC register: load has priority over increment.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         pc_reg <= RESET_VECTOR;
      end else if (LOAD) begin
         pc_reg <= LOAD_PC;
      end else if (INC) begin
         pc_reg <= pc_reg + PC_INC;
      end
   end

   assign PC = pc_reg;

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch unit: issues one word request per instruction, holds the
// returned word for decode, and follows redirects from execute. A misaligned
// redirect target halts fetch with a sticky FAULT until reset.
module mips_ifetch
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            REDIRECT,
   input  logic [PC_W-1:0] REDIRECT_PC,
   output logic            IMEM_REQ,
   output logic [PC_W-1:0] IMEM_ADDR,
   input  logic            IMEM_GNT,
   input  logic            IMEM_RVALID,
   input  logic [31:0]     IMEM_RDATA,
   output logic            INSTR_VALID,
   output logic [31:0]     INSTR,
   output logic [PC_W-1:0] INSTR_PC,
   input  logic            INSTR_READY,
   output logic            FAULT
);

   fetch_state_t    state_reg, state_next;
   logic            kill_reg, kill_next;
   logic [31:0]     instr_reg, instr_next;
   logic [PC_W-1:0] instr_pc_reg, instr_pc_next;
   logic            instr_valid_reg, instr_valid_next;
   logic            fault_reg, fault_next;

   logic            pc_load;
   logic            pc_inc;
   logic [PC_W-1:0] pc;
   logic            bad_redirect;

   mips_fetch_pc #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .CLK     (CLK),
      .RESET   (RESET),
      .LOAD    (pc_load),
      .LOAD_PC (REDIRECT_PC),
      .INC     (pc_inc),
      .PC      (pc)
   );

   assign bad_redirect = REDIRECT && is_misaligned(REDIRECT_PC);

   // Next-state and register-update logic; a bad redirect overrides all.
   always_comb begin
      state_next       = state_reg;
      kill_next        = kill_reg;
      instr_next       = instr_reg;
      instr_pc_next    = instr_pc_reg;
      instr_valid_next = instr_valid_reg;
      fault_next       = fault_reg;
      pc_load          = 1'b0;
      pc_inc           = 1'b0;

      if ((state_reg != ST_HALT) && bad_redirect) begin
         state_next       = ST_HALT;
         fault_next       = 1'b1;
         instr_valid_next = 1'b0;
         kill_next        = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               pc_load    = REDIRECT;
               state_next = ST_REQ;
            end
            ST_REQ: begin
               // A redirect wins over a grant; the granted access is dropped.
               if (REDIRECT) begin
                  pc_load = 1'b1;
               end else if (IMEM_GNT) begin
                  state_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (REDIRECT) begin
                  pc_load = 1'b1;
                  if (IMEM_RVALID) begin
                     kill_next  = 1'b0;
                     state_next = ST_REQ;
                  end else begin
                     kill_next = 1'b1;
                  end
               end else if (IMEM_RVALID) begin
                  if (kill_reg) begin
                     kill_next  = 1'b0;
                     state_next = ST_REQ;
                  end else begin
                     instr_next       = IMEM_RDATA;
                     instr_pc_next    = pc;
                     instr_valid_next = 1'b1;
                     pc_inc           = 1'b1;
                     state_next       = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (REDIRECT) begin
                  pc_load          = 1'b1;
                  instr_valid_next = 1'b0;
                  state_next       = ST_REQ;
               end else if (INSTR_READY) begin
                  instr_valid_next = 1'b0;
                  state_next       = ST_REQ;
               end
            end
            ST_HALT: begin
               state_next = ST_HALT;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset dominates every other input.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_reg       <= ST_IDLE;
         kill_reg        <= 1'b0;
         instr_reg       <= '0;
         instr_pc_reg    <= '0;
         instr_valid_reg <= 1'b0;
         fault_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         kill_reg        <= kill_next;
         instr_reg       <= instr_next;
         instr_pc_reg    <= instr_pc_next;
         instr_valid_reg <= instr_valid_next;
         fault_reg       <= fault_next;
      end
   end

   assign IMEM_REQ    = (state_reg == ST_REQ);
   assign IMEM_ADDR   = IMEM_REQ ? pc : '0;
   assign INSTR_VALID = instr_valid_reg;
   assign INSTR       = instr_reg;
   assign INSTR_PC    = instr_pc_reg;
   assign FAULT       = fault_reg;

endmodule
